// File: rtl/mc_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_exec_pkg
//  Description : Shared op/state encodings and helpers for mc_exec_unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_exec_pkg;

    typedef enum logic [2:0] {
        OP_SLL  = 3'd0,
        OP_SRL  = 3'd1,
        OP_SRA  = 3'd2,
        OP_RSVD = 3'd3,
        OP_DIV  = 3'd4,
        OP_DIVU = 3'd5,
        OP_REM  = 3'd6,
        OP_REMU = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_rem(input op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div(input op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_exec_divstep.sv
`default_nettype none
// ============================================================================
//  Module      : mc_exec_divstep
//  Description : One combinational restoring-division iteration.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_exec_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_dividend_bit,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q_bit
);

    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_diff;

    // i_rem < i_divisor always holds, so the difference fits in XLEN bits
    assign w_trial = {i_rem, i_dividend_bit};
    assign o_q_bit = (w_trial >= {1'b0, i_divisor});
    assign w_diff  = w_trial[XLEN-1:0] - i_divisor;
    assign o_rem   = o_q_bit ? w_diff : w_trial[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mc_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mc_exec_unit
//  Description : Multi-cycle shifter / radix-2 divider with valid/ready and tag.
//                MC_EXEC_DIV_EARLY_EXIT_EN skips leading-zero divide iterations.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_unknown,
    output logic             done_pre,
    output logic             busy
);
    import mc_exec_pkg::*;

    localparam int c_AMT_W = $clog2(XLEN);
    localparam int c_CNT_W = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_STEP     = c_CNT_W'(SHIFT_STEP);
    localparam logic [c_CNT_W-1:0] c_XLEN_CNT = c_CNT_W'(XLEN);

    state_t              r_state, w_state_nxt, w_start_state;
    op_t                 r_op, w_op;
    logic [XLEN-1:0]     r_result, r_acc, r_rem, r_dvs;
    logic [c_CNT_W-1:0]  r_cnt, w_step;
    logic [TAG_W-1:0]    r_tag;
    logic                r_unknown, r_neg_q, r_neg_r;
    logic                w_accept, w_sgn, w_a_neg, w_b_neg, w_b_zero, w_ovf;
    logic [XLEN-1:0]     w_a_mag, w_b_mag, w_shl, w_shr, w_sra, w_shifted, w_fix;
    logic [XLEN-1:0]     w_ds_rem_in, w_ds_dvs, w_ds_rem;
    logic                w_ds_bit, w_ds_q;

    assign w_op     = op_t'(op);
    assign in_ready = !flush && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    assign w_sgn    = is_signed_div(w_op);
    assign w_a_neg  = w_sgn && a[XLEN-1];
    assign w_b_neg  = w_sgn && b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_ovf    = w_sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef MC_EXEC_DIV_EARLY_EXIT_EN
    logic [c_CNT_W-1:0] w_clz;

    always_comb begin
        w_clz = c_XLEN_CNT;
        for (int i = 0; i < XLEN; i++) begin
            if (w_a_mag[i]) w_clz = c_CNT_W'(XLEN - 1 - i);
        end
    end

    assign w_ds_rem_in = r_rem;
    assign w_ds_dvs    = r_dvs;
    assign w_ds_bit    = r_acc[XLEN-1];
`else
    // Outside DIV the divstep resolves the first quotient bit on the accept edge
    assign w_ds_rem_in = (r_state == ST_DIV) ? r_rem : '0;
    assign w_ds_dvs    = (r_state == ST_DIV) ? r_dvs : w_b_mag;
    assign w_ds_bit    = (r_state == ST_DIV) ? r_acc[XLEN-1] : w_a_mag[XLEN-1];
`endif

    mc_exec_divstep #(.XLEN(XLEN)) u_divstep (
        .i_rem          (w_ds_rem_in),
        .i_divisor      (w_ds_dvs),
        .i_dividend_bit (w_ds_bit),
        .o_rem          (w_ds_rem),
        .o_q_bit        (w_ds_q)
    );

    assign w_step    = (r_cnt <= c_STEP) ? r_cnt : c_STEP;
    assign w_shl     = r_result << w_step;
    assign w_shr     = r_result >> w_step;
    assign w_sra     = $signed(r_result) >>> w_step;
    assign w_shifted = (r_op == OP_SLL) ? w_shl : ((r_op == OP_SRA) ? w_sra : w_shr);
    assign w_fix     = is_rem(r_op) ? (r_neg_r ? -r_rem : r_rem)
                                    : (r_neg_q ? -r_acc : r_acc);

    always_comb begin
        w_start_state = ST_DONE;
        if (w_op == OP_RSVD) begin
            w_start_state = ST_DONE;
        end else if (!is_div(w_op)) begin
            w_start_state = (b[c_AMT_W-1:0] == '0) ? ST_DONE : ST_SHIFT;
        end else if (w_b_zero || w_ovf) begin
            w_start_state = ST_DONE;
        end else begin
`ifdef MC_EXEC_DIV_EARLY_EXIT_EN
            w_start_state = (w_clz == c_XLEN_CNT) ? ST_FIX : ST_DIV;
`else
            w_start_state = ST_DIV;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  w_state_nxt = ST_IDLE;
            ST_SHIFT: if (r_cnt <= c_STEP) w_state_nxt = ST_DONE;
            ST_DIV:   if (r_cnt == c_CNT_W'(1)) w_state_nxt = ST_FIX;
            ST_FIX:   w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_accept) w_state_nxt = w_start_state;
        if (flush)    w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= OP_SLL;
            r_result  <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_tag     <= '0;
            r_unknown <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= w_op;
                r_tag     <= tag;
                r_unknown <= (w_op == OP_RSVD);
                r_dvs     <= w_b_mag;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
                if (w_op == OP_RSVD) begin
                    r_result <= '0;
                end else if (!is_div(w_op)) begin
                    r_result <= a;
                    r_cnt    <= {1'b0, b[c_AMT_W-1:0]};
                end else if (w_b_zero) begin
                    r_result <= is_rem(w_op) ? a : '1;
                end else if (w_ovf) begin
                    r_result <= is_rem(w_op) ? '0 : a;
                end else begin
`ifdef MC_EXEC_DIV_EARLY_EXIT_EN
                    r_rem <= '0;
                    r_acc <= w_a_mag << w_clz;
                    r_cnt <= c_XLEN_CNT - w_clz;
`else
                    r_rem <= w_ds_rem;
                    r_acc <= {w_a_mag[XLEN-2:0], w_ds_q};
                    r_cnt <= c_XLEN_CNT - c_CNT_W'(1);
`endif
                end
            end else begin
                unique case (r_state)
                    ST_SHIFT: begin
                        r_result <= w_shifted;
                        r_cnt    <= r_cnt - w_step;
                    end
                    ST_DIV: begin
                        r_rem <= w_ds_rem;
                        r_acc <= {r_acc[XLEN-2:0], w_ds_q};
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                    ST_FIX:  r_result <= w_fix;
                    default: ;
                endcase
            end
            if (flush) r_unknown <= 1'b0;
        end
    end

    assign out_valid   = (r_state == ST_DONE);
    assign result      = r_result;
    assign out_tag     = r_tag;
    assign out_unknown = r_unknown;
    assign busy        = (r_state != ST_IDLE);
    assign done_pre    = ((r_state == ST_SHIFT) && (r_cnt <= c_STEP)) || (r_state == ST_FIX);

endmodule
`default_nettype wire

// File: tb/tb_mc_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_exec_unit
//  Description : Self-checking bench for mc_exec_unit (XLEN=32, SHIFT_STEP=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        out_unknown;
    logic        done_pre;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res;

    mc_exec_unit #(.XLEN(32), .SHIFT_STEP(4), .TAG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .tag         (tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .out_tag     (out_tag),
        .out_unknown (out_unknown),
        .done_pre    (done_pre),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Returns {unknown, result} straight from the ISA definition of each op
    function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [4:0]  amt;
        logic [31:0] r;
        logic        ovf;
        amt = y[4:0];
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r   = '0;
        case (o)
            3'd0: r = x << amt;
            3'd1: r = x >> amt;
            3'd2: r = $signed(x) >>> amt;
            3'd3: return {1'b1, 32'h0};
            3'd4: if (y == 0) r = '1; else if (ovf) r = x; else r = $signed(x) / $signed(y);
            3'd5: if (y == 0) r = '1; else r = x / y;
            3'd6: if (y == 0) r = x; else if (ovf) r = '0; else r = $signed(x) % $signed(y);
            default: if (y == 0) r = x; else r = x % y;
        endcase
        return {1'b0, r};
    endfunction

    function automatic int lat_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int unsigned mag;
        int          n;
        if (o == 3'd3) return 1;
        if (o < 3'd3) return (int'(y[4:0]) + 3) / 4 + 1;
        if (y == 0) return 1;
        if (o[0] == 1'b0 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MC_EXEC_DIV_EARLY_EXIT_EN
        mag = (o[0] == 1'b0 && x[31]) ? -x : x;
        n = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
        return n + 2;
`else
        mag = x;
        n = 0;
        return 33;
`endif
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] t);
        logic [32:0] exp;
        int exp_lat, lat, pre_cnt;
        exp     = model(o, va, vb);
        exp_lat = lat_model(o, va, vb);
        @(negedge clk);
        op = o; a = va; b = vb; tag = t; in_valid = 1'b1; out_ready = 1'b1;
        #1 check("in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        pre_cnt = 0;
        while (!out_valid && lat < 100) begin
            pre_cnt += int'(done_pre);
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency op%0d", o), lat, exp_lat);
        check($sformatf("result op%0d a=%h b=%h", o, va, vb), result, exp[31:0]);
        check("out_unknown", out_unknown, exp[32]);
        check("out_tag", out_tag, t);
        check("done_pre count", pre_cnt, (exp_lat > 1) ? 1 : 0);
        last_res = result;
        @(posedge clk); #1;
        check("idle after handshake", busy, 0);
    endtask

    initial begin
        int cyc;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst result", result, 0);
        check("rst out_tag", out_tag, 0);
        check("rst out_unknown", out_unknown, 0);
        check("rst busy", busy, 0);
        check("rst done_pre", done_pre, 0);
        @(negedge clk) reset = 1'b1;

        do_op(3'd2, 32'h8000_0000, 32'd35, 5'd1);
        check("plan sra", last_res, 32'hF000_0000);
        do_op(3'd0, 32'd1, 32'd31, 5'd2);
        check("plan sll", last_res, 32'h8000_0000);
        do_op(3'd1, 32'hF0, 32'd0, 5'd3);
        check("plan srl0", last_res, 32'hF0);
        do_op(3'd4, -32'sd7, 32'd2, 5'd4);
        check("plan div", last_res, 32'hFFFF_FFFD);
        do_op(3'd6, -32'sd7, 32'd2, 5'd5);
        check("plan rem", last_res, 32'hFFFF_FFFF);
        do_op(3'd5, 32'd5, 32'd0, 5'd6);
        check("plan divu0", last_res, 32'hFFFF_FFFF);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        check("plan div ovf", last_res, 32'h8000_0000);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        do_op(3'd3, 32'h1234, 32'h5678, 5'd9);
        do_op(3'd7, 32'hFFFF_FFFF, 32'd10, 5'd10);
        do_op(3'd4, 32'd0, 32'd3, 5'd11);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = '1;
                2: rb = $urandom_range(1, 9);
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            do_op(ro, ra, rb, 5'($urandom_range(0, 31)));
        end

        // back-pressure then back-to-back accept on the releasing edge
        @(negedge clk);
        op = 3'd5; a = 32'd100; b = 32'd7; tag = 5'd9; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        check("bp out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp result", result, 32'd14);
            check("bp out_tag", out_tag, 9);
            check("bp in_ready", in_ready, 0);
            check("bp held", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd1; a = 32'hABCD_0000; b = 32'd4; tag = 5'd17;
        #1 check("b2b in_ready", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        check("b2b started", busy, 1);
        check("b2b not done", out_valid, 0);
        @(posedge clk); #1;
        check("b2b out_valid", out_valid, 1);
        check("b2b result", result, 32'h0ABC_D000);
        check("b2b out_tag", out_tag, 17);
        @(posedge clk); #1;

        // flush during divide iterations
        @(negedge clk);
        op = 3'd4; a = 32'd1000; b = 32'd3; tag = 5'd3; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; tag = 5'd5;
        #1 check("flush in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("flush busy", busy, 0);
        check("flush out_valid", out_valid, 0);
        check("flush out_unknown", out_unknown, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 check("post flush in_ready", in_ready, 1);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            cyc += int'(out_valid);
        end
        check("flush no out_valid", cyc, 0);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        op = 3'd0; a = 32'd1; b = 32'd31; tag = 5'd21; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid shift busy", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("async rst result", result, 0);
        check("async rst out_tag", out_tag, 0);
        check("async rst busy", busy, 0);
        check("async rst out_valid", out_valid, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("post rst idle", busy, 0);
        do_op(3'd2, 32'h8765_4321, 32'd8, 5'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_exec_unit.md
Name: mc_exec_unit

Overview:
- Parametrised multi-cycle execution unit for the core's long-latency integer ops: iterative shifter (SLL/SRL/SRA, SHIFT_STEP bits per cycle) and radix-2 divider (DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU/MUL in the execute stage.
- Replaces ad-hoc kick/ready sequencing with valid/ready handshakes and a result tag, so the stage can stall on back-pressure and flush on redirect.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHIFT_STEP, 1, max shift distance per cycle; power of two, 1..XLEN.
- TAG_W, 5, width of the opaque tag (destination register index).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- op  in  3  operation code (mc_exec_pkg::op_t).
- a  in  XLEN  shift source / dividend.
- b  in  XLEN  shift amount (low log2(XLEN) bits) / divisor.
- tag  in  TAG_W  carried to out_tag unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  shift result, quotient or remainder.
- out_tag  out  TAG_W  tag of the completed op.
- out_unknown  out  1  op was a reserved encoding.
- done_pre  out  1  out_valid rises at the next edge.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_valid, result, out_tag, out_unknown and all internal counters = 0. Reset mid-operation discards the op.
- Op encoding: 0 SLL, 1 SRL, 2 SRA, 3 reserved, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States: IDLE, SHIFT, DIV, FIX, DONE.
- in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
- Accept = in_valid && in_ready. On accept, latch a, b, op and tag.
- Latency (edges from the accept edge to out_valid=1):
  - Reserved op: 1 edge; result=0, out_unknown=1.
  - Shift, amt = b[log2(XLEN)-1:0]: enter SHIFT with rem=amt. Each edge shifts by min(rem, SHIFT_STEP) and subtracts it. At the edge where rem==0, go to DONE. Total ceil(amt/SHIFT_STEP)+1 edges; amt=0 gives 1 edge, result=a. SRA fills with a[XLEN-1]; SLL/SRL fill with 0.
  - Divide by zero (b==0): 1 edge. Quotient = all ones; remainder = a.
  - Signed overflow (DIV/REM, a = min signed, b = -1): 1 edge. Quotient = a; remainder = 0.
  - Other divides: enter DIV with operand magnitudes and count=XLEN. Restoring division, one quotient bit per edge. When count reaches 0, go to FIX. FIX applies signs (quotient negated if the operand signs differ; remainder takes the dividend's sign), then goes to DONE. Total XLEN+1 edges.
- DONE: out_valid=1. result, out_tag and out_unknown hold stable until out_valid && out_ready.
  - Handshake with no new accept: go to IDLE.
  - Handshake with a simultaneous accept: start the new op the same edge (back-to-back).
- done_pre = 1 in SHIFT when rem <= SHIFT_STEP, and in FIX. It is 0 in IDLE, DONE and DIV; 1-edge ops give no pre-warning.
- flush = 1 at an edge: state=IDLE, out_valid=0, out_unknown=0; any in_valid that cycle is not accepted. result and out_tag are don't-care after a flush.

Optional Feature:
- Macro: MC_EXEC_DIV_EARLY_EXIT_EN.
- Defined: a regular divide pre-shifts the dividend magnitude by its leading-zero count and runs max(XLEN - clz(|a|), 0) iterations. |a|=0 goes straight to FIX. Latency = iterations + 2 edges.
- Not defined: always XLEN iterations; no leading-zero counter is instantiated.
- Results are identical either way; only latency and done_pre timing differ.

Decomposition:
- mc_exec_pkg: op_t enum and its values, state_t enum, and a helper function is_div(op).
- Sub-module mc_exec_divstep: combinational single restoring iteration (partial remainder, divisor, dividend bit in -> new remainder and quotient bit).
- Leading-zero count stays inline, under the macro.

Test Plan (XLEN=32, SHIFT_STEP=4, macro off unless noted):
- SRA a=0x8000_0000, b=35 (amt 3) -> result 0xF000_0000, out_valid 2 edges after accept, done_pre high the cycle before.
- SLL a=1, b=31 -> 0x8000_0000 after 9 edges. SRL a=0xF0, b=0 -> 0xF0 after 1 edge.
- DIV a=-7, b=2 -> 0xFFFF_FFFD after 33 edges; REM same operands -> 0xFFFF_FFFF. With MC_EXEC_DIV_EARLY_EXIT_EN -> same values after 5 edges.
- DIVU a=5, b=0 -> 0xFFFF_FFFF after 1 edge. DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000. REM same operands -> 0. Op 3 -> out_unknown=1, result=0.
- Back-pressure: out_ready=0 for 5 cycles -> result/out_tag stable, in_ready=0. Then out_ready=1 with in_valid=1 and a new op -> handshake and accept on the same edge; new result carries the new tag.
- flush at DIV iteration 10 -> out_valid never rises, in_ready=1 next cycle. Assert reset mid-SHIFT -> outputs 0 immediately (asynchronous), IDLE after release.
